// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: load/store decode keys and the memory-stage state type.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // Match keys are {funct3, opcode}, compared against {instr[14:12], instr[6:0]}.
  localparam logic [9:0] LB  = {3'b000, OPC_LOAD};
  localparam logic [9:0] LH  = {3'b001, OPC_LOAD};
  localparam logic [9:0] LW  = {3'b010, OPC_LOAD};
  localparam logic [9:0] LBU = {3'b100, OPC_LOAD};
  localparam logic [9:0] LHU = {3'b101, OPC_LOAD};
  localparam logic [9:0] SB  = {3'b000, OPC_STORE};
  localparam logic [9:0] SH  = {3'b001, OPC_STORE};
  localparam logic [9:0] SW  = {3'b010, OPC_STORE};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  function automatic logic [9:0] mem_key(input logic [31:0] instr);
    return {instr[14:12], instr[6:0]};
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/grant/response port between the memory stage and data memory.
interface mem_access_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
endinterface

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword lane of a load word and sign- or zero-extends it.
module load_extend (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    byte_sel = lane[addr];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      3'b000:  data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  data = {{16{half_sel[15]}}, half_sel};
      3'b100:  data = {24'h0, byte_sel};
      3'b101:  data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// RV32I memory-access stage: issues loads/stores on the dmem port, passes other
// instructions through to write-back with one cycle of latency.
module mem_access
  import riscv_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [31:0]         instr_i,
  input  logic [31:0]         alu_result_i,
  input  logic [31:0]         rs2_i,
  mem_access_if.master        dmem,
  output logic                valid_o,
  output logic [31:0]         instr_o,
  output logic [31:0]         result_o,
  output logic                misalign_o
);

  mem_state_t  state_reg, state_next;

  logic        is_load, is_store, mis_dec;
  logic [3:0]  be_dec;
  logic [31:0] wdata_dec;
  logic        accept, mem_go;

  logic        we_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic [3:0]  be_reg;
  logic [1:0]  off_reg;
  logic [2:0]  funct3_reg;

  logic        valid_reg, valid_next;
  logic        misalign_reg, misalign_next;
  logic [31:0] result_reg, result_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] ext_data;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    mis_dec   = 1'b0;
    be_dec    = 4'b0000;
    wdata_dec = 32'h0;
    casez (mem_key(instr_i))
      LB, LBU: is_load = 1'b1;
      LH, LHU: begin
        is_load = 1'b1;
        mis_dec = alu_result_i[0];
      end
      LW: begin
        is_load = 1'b1;
        mis_dec = |alu_result_i[1:0];
      end
      SB: begin
        is_store  = 1'b1;
        be_dec    = 4'b0001 << alu_result_i[1:0];
        wdata_dec = {4{rs2_i[7:0]}};
      end
      SH: begin
        is_store  = 1'b1;
        mis_dec   = alu_result_i[0];
        be_dec    = alu_result_i[1] ? 4'b1100 : 4'b0011;
        wdata_dec = {2{rs2_i[15:0]}};
      end
      SW: begin
        is_store  = 1'b1;
        mis_dec   = |alu_result_i[1:0];
        be_dec    = 4'b1111;
        wdata_dec = rs2_i;
      end
      default: ;
    endcase
  end

  assign accept = valid_i && ready_o;
  assign mem_go = accept && (is_load || is_store) && !mis_dec;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (mem_go) state_next = REQ;
      REQ:     if (dmem.dmem_gnt_i) state_next = we_reg ? IDLE : WAIT;
      WAIT:    if (dmem.dmem_rvalid_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_o       = (state_reg == IDLE);
    valid_next    = 1'b0;
    misalign_next = misalign_reg;
    result_next   = result_reg;
    instr_next    = instr_reg;
    case (state_reg)
      IDLE: if (accept) begin
        instr_next    = instr_i;
        misalign_next = mis_dec;
        if (!mem_go) begin
          valid_next  = 1'b1;
          result_next = mis_dec ? 32'h0 : alu_result_i;
        end
      end
      REQ: if (dmem.dmem_gnt_i && we_reg) begin
        valid_next  = 1'b1;
        result_next = 32'h0;
      end
      WAIT: if (dmem.dmem_rvalid_i) begin
        valid_next  = 1'b1;
        result_next = ext_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg    <= 1'b0;
      misalign_reg <= 1'b0;
      result_reg   <= 32'h0;
      instr_reg    <= 32'h0;
      we_reg       <= 1'b0;
      addr_reg     <= 32'h0;
      be_reg       <= 4'b0000;
      wdata_reg    <= 32'h0;
      off_reg      <= 2'b00;
      funct3_reg   <= 3'b000;
    end else begin
      valid_reg    <= valid_next;
      misalign_reg <= misalign_next;
      result_reg   <= result_next;
      instr_reg    <= instr_next;
      // Request fields are captured once at accept and held through REQ/WAIT.
      if (mem_go) begin
        we_reg     <= is_store;
        addr_reg   <= {alu_result_i[31:2], 2'b00};
        be_reg     <= is_store ? be_dec : 4'b1111;
        wdata_reg  <= wdata_dec;
        off_reg    <= alu_result_i[1:0];
        funct3_reg <= instr_i[14:12];
      end
    end
  end

  load_extend u_load_extend (
    .rdata  (dmem.dmem_rdata_i),
    .addr   (off_reg),
    .funct3 (funct3_reg),
    .data   (ext_data)
  );

  assign dmem.dmem_req_o   = (state_reg == REQ);
  assign dmem.dmem_we_o    = we_reg;
  assign dmem.dmem_addr_o  = addr_reg;
  assign dmem.dmem_be_o    = be_reg;
  assign dmem.dmem_wdata_o = wdata_reg;

  assign valid_o    = valid_reg;
  assign misalign_o = misalign_reg;
  assign result_o   = result_reg;
  assign instr_o    = instr_reg;

endmodule
